fpadd_arbiter: RTL and testbench

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_pkg.sv | 30 +++
 rtl/fpadd_tag_pipe.sv | 46 ++++
 rtl/fpadd_arbiter.sv | 118 +++++++++++
 tb/tb_fpadd_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP32 adder arbiter: operand width, default adder
// latency, requester id and the in-flight tag carried alongside each issue.
package fpadd_pkg;

   localparam int FP_W            = 32;
   localparam int DEFAULT_LATENCY = 3;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   // Round-robin pick: on contention the requester not granted last wins,
   // otherwise whichever requester is valid.
   function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last);
      req_id_t pick;
      if (v0 && v1) begin
         pick = (last == REQ0) ? REQ1 : REQ0;
      end else begin
         pick = v1 ? REQ1 : REQ0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/fpadd_tag_pipe.sv
// Tag shift register that tracks which requester owns the adder result
// arriving LATENCY cycles after each issue. The tail entry lines up with
// add_res; busy reports any valid tag still in flight.
module fpadd_tag_pipe
   import fpadd_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_id,
   output logic tail_valid,
   output logic tail_id,
   output logic busy
);

   tag_t pipe [LATENCY];

   // Shift a new tag in every cycle; non-issue cycles insert an invalid tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: every stage is reset so operations in flight at reset are
         // dropped and never produce a response after release.
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= '{valid: in_valid, id: req_id_t'(in_id)};
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Busy is the OR of all tag valid bits; tail exposes the oldest entry.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         busy = busy | pipe[i].valid;
      end
      tail_valid = pipe[LATENCY-1].valid;
      tail_id    = pipe[LATENCY-1].id;
   end

endmodule

// File: rtl/fpadd_arbiter.sv
// Two-requester round-robin arbiter in front of an external pipelined FP32
// adder. One operand pair issues per cycle unless hold is high; results come
// back in issue order as a one-cycle pulse to the owning requester.
// Optional feature: define FPADD_ARB_STATS_EN to add saturating per-requester
// grant counters gnt_cnt0/gnt_cnt1.
module fpadd_arbiter
   import fpadd_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int CNT_W   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [FP_W-1:0] req0_a,
   input  logic [FP_W-1:0] req0_b,
   input  logic            req1_valid,
   input  logic [FP_W-1:0] req1_a,
   input  logic [FP_W-1:0] req1_b,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic            hold,
   output logic [FP_W-1:0] add_a,
   output logic [FP_W-1:0] add_b,
   input  logic [FP_W-1:0] add_res,
   output logic            rsp0_valid,
   output logic            rsp1_valid,
   output logic [FP_W-1:0] rsp_data,
`ifdef FPADD_ARB_STATS_EN
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
`endif
   output logic            busy
);

   if (LATENCY < 1 || CNT_W < 1) begin : g_param_check
      $error("fpadd_arbiter: LATENCY and CNT_W must both be at least 1");
   end

   req_id_t last_gnt;
   req_id_t gnt_id;
   logic    issue;
   logic    tail_valid;
   logic    tail_id;

   // Grant selection and operand steering; reset gates issue so no ready
   // escapes combinationally while reset is low.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      issue      = (req0_valid | req1_valid) & ~hold & reset;
      gnt_id     = rr_pick(req0_valid, req1_valid, last_gnt);
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      add_a      = '0;
      add_b      = '0;
      if (issue) begin
         if (gnt_id == REQ1) begin
            req1_ready = 1'b1;
            add_a      = req1_a;
            add_b      = req1_b;
         end else begin
            req0_ready = 1'b1;
            add_a      = req0_a;
            add_b      = req0_b;
         end
      end
   end

   // Round-robin pointer: remembers the last granted requester; reset makes
   // requester 0 win the first contention.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_gnt <= REQ1;
      end else if (issue) begin
         // NOTE: state updates use non-blocking assignment so every flop
         // samples values from before the clock edge.
         last_gnt <= gnt_id;
      end
   end

   fpadd_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (issue),
      .in_id      (gnt_id),
      .tail_valid (tail_valid),
      .tail_id    (tail_id),
      .busy       (busy)
   );

   // Route the adder result to the requester named by the tail tag.
   always_comb begin
      rsp0_valid = tail_valid & (tail_id == REQ0);
      rsp1_valid = tail_valid & (tail_id == REQ1);
      rsp_data   = tail_valid ? add_res : '0;
   end

`ifdef FPADD_ARB_STATS_EN
   // Per-requester grant counters, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (issue) begin
         if (gnt_id == REQ0 && !(&gnt_cnt0)) begin
            gnt_cnt0 <= gnt_cnt0 + 1'b1;
         end
         if (gnt_id == REQ1 && !(&gnt_cnt1)) begin
            gnt_cnt1 <= gnt_cnt1 + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: a driver issues directed and random
// operand pairs and pushes expected responses; a monitor pops and compares
// whenever a response pulse appears. The external adder is modelled here as a
// LATENCY-deep pipeline of real-valued FP32 sums.
module tb_fpadd_arbiter;

   localparam int LAT   = 3;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0] add_a, add_b, add_res, rsp_data;
`ifdef FPADD_ARB_STATS_EN
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

   fpadd_arbiter #(.LATENCY(LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready), .hold(hold),
      .add_a(add_a), .add_b(add_b), .add_res(add_res),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
`ifdef FPADD_ARB_STATS_EN
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // FP32 <-> real conversion for normal numbers and zero.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      int          e;
      if (f[30:0] == 31'd0) return 0.0;
      e = int'(f[30:23]) - 127 + 1023;
      d = {f[31], e[10:0], f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // External shared adder: result appears LAT cycles after the operands.
   logic [31:0] res_pipe [LAT];
   initial for (int i = 0; i < LAT; i++) res_pipe[i] = '0;
   always @(posedge clk) begin
      res_pipe[0] <= r2f(f2r(add_a) + f2r(add_b));
      for (int i = 1; i < LAT; i++) res_pipe[i] <= res_pipe[i-1];
   end
   assign add_res = res_pipe[LAT-1];

   typedef struct {
      logic        id;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic last_model = 1'b1;
   int   gcnt0 = 0, gcnt1 = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: busy against in-flight issues, and every response against the
   // oldest scoreboard entry (id, data, issue-to-response latency).
   always @(negedge clk) begin
      logic exp_busy;
      exp_t e;
      exp_busy = 1'b0;
      foreach (sb[i]) if (sb[i].cyc < cyc) exp_busy = 1'b1;
      check("busy", 32'(busy), 32'(exp_busy));
      if (rsp0_valid || rsp1_valid) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_id", {30'd0, rsp1_valid, rsp0_valid}, e.id ? 32'd2 : 32'd1);
            check("rsp_data", rsp_data, e.data);
            check("rsp_latency", 32'(cyc - e.cyc), 32'(LAT));
         end
      end else if (sb.size() > 0 && sb[0].cyc + LAT <= cyc) begin
         e = sb.pop_front();
         check("rsp_missing", {30'd0, rsp1_valid, rsp0_valid}, e.id ? 32'd2 : 32'd1);
      end
   end

   // One driven cycle: apply inputs, check the combinational grant against the
   // round-robin rule, and record the expected response.
   task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic h, input logic use_fixed, input logic [31:0] fixed);
      logic        issue, gnt;
      logic [31:0] ea, eb;
      @(posedge clk);
      #1;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      hold = h;
      #2;
      issue = (v0 | v1) & ~h;
      gnt   = (v0 && v1) ? ~last_model : v1;
      ea    = issue ? (gnt ? a1 : a0) : 32'h0;
      eb    = issue ? (gnt ? b1 : b0) : 32'h0;
      check("req0_ready", 32'(req0_ready), 32'(issue && !gnt));
      check("req1_ready", 32'(req1_ready), 32'(issue && gnt));
      check("add_a", add_a, ea);
      check("add_b", add_b, eb);
      if (issue) begin
         sb.push_back('{id: gnt, data: use_fixed ? fixed : r2f(f2r(ea) + f2r(eb)), cyc: cyc});
         last_model = gnt;
         if (gnt) gcnt1 = (gcnt1 == 65535) ? gcnt1 : gcnt1 + 1;
         else     gcnt0 = (gcnt0 == 65535) ? gcnt0 : gcnt0 + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Assert reset for one cycle with both requesters valid; outputs must be 0.
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      last_model = 1'b1;
      gcnt0 = 0; gcnt1 = 0;
      req0_valid = 1'b1; req1_valid = 1'b1; hold = 1'b0;
      req0_a = 32'h3F800000; req0_b = 32'h3F800000;
      req1_a = 32'h40000000; req1_b = 32'h40000000;
      #2;
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_add_a", add_a, 32'h0);
      check("rst_add_b", add_b, 32'h0);
      check("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] rnd_op();
      int v;
      v = int'($urandom_range(16)) - 8;
      return r2f(real'(v));
   endfunction

   initial begin
      int w;
      do_reset();

      // Single requester: 1.0 + 2.0 = 3.0 back to req0 after LAT cycles.
      step(1, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1, 32'h40400000);
      idle(LAT + 1);

      // Continuous contention after reset: grants alternate starting at req0.
      do_reset();
      for (int i = 0; i < 4; i++)
         step(1, r2f(real'(i)), 32'h3F800000, 1, r2f(real'(i + 10)), 32'h40000000, 0, 0, 0);
      idle(LAT + 1);

      // Hold blocks issue while the in-flight operation drains.
      step(1, 32'h40000000, 32'h40000000, 1, 32'h40400000, 32'h40400000, 0, 0, 0);
      for (int i = 0; i < LAT + 2; i++)
         step(1, 32'h40000000, 32'h40000000, 1, 32'h40400000, 32'h40400000, 1, 0, 0);

      // Reset one cycle after two issues drops them; next contention goes to req0.
      step(1, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 32'h40000000, 0, 0, 0);
      step(1, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 32'h40000000, 0, 0, 0);
      do_reset();
      idle(LAT + 2);
      step(1, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 32'h40000000, 0, 0, 0);
      idle(LAT + 1);

      // 3.0 + -3.0 on req1 gives +0.0.
      step(0, 0, 0, 1, 32'h40400000, 32'hC0400000, 0, 1, 32'h00000000);
      idle(LAT + 1);

      // Randomized traffic with occasional hold.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(1)), rnd_op(), rnd_op(),
              1'($urandom_range(1)), rnd_op(), rnd_op(),
              ($urandom_range(3) == 0), 0, 0);

`ifdef FPADD_ARB_STATS_EN
      idle(LAT + 1);
      check("gnt_cnt0_rand", 32'(gnt_cnt0), 32'(gcnt0));
      check("gnt_cnt1_rand", 32'(gnt_cnt1), 32'(gcnt1));
      do_reset();
      for (int i = 0; i < 70000; i++)
         step(1, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 1, 32'h40000000);
      idle(LAT + 1);
      check("gnt_cnt0_sat", 32'(gnt_cnt0), 32'h0000FFFF);
      check("gnt_cnt1_zero", 32'(gnt_cnt1), 32'h0);
`endif

      // Bounded drain of the scoreboard.
      w = 0;
      while (sb.size() > 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      check("drain", 32'(sb.size()), 32'd0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
